// File: rtl/d_pkg.sv
// ----------------------------------------------------------------------------
// d_pkg
//
// Purpose
//   Shared constants for the register file / scoreboard slice: default data
//   width, register count and maximum result latency, plus the address and
//   latency widths derived from them. Also holds the latency clamp helper so
//   every user of an issue latency applies the same rule.
//
// Contents
//   D_DW, D_NREG, D_NR, D_MAXLAT : default parameter values
//   D_AW, D_LW                   : derived address / counter widths
//   clamp_lat()                  : folds a raw latency into 1..maxlat
// ----------------------------------------------------------------------------
package d_pkg;

    localparam int D_DW     = 32;
    localparam int D_NREG   = 32;
    localparam int D_NR     = 2;
    localparam int D_MAXLAT = 3;

    // Register address width and scoreboard counter width.
    localparam int D_AW = $clog2(D_NREG);
    localparam int D_LW = $clog2(D_MAXLAT + 1);

    // A zero latency would leave the destination looking ready while the
    // result is still in flight, so it is treated as one cycle. Latencies
    // above the pipeline depth are folded down to the deepest stage.
    // Evaluated on int so that narrow latency fields do not turn the range
    // checks into constant comparisons.
    function automatic int clamp_lat(input int lat, input int maxlat);
        int res;
        res = lat;
        if (res < 1) begin
            res = 1;
        end
        if (res > maxlat) begin
            res = maxlat;
        end
        return res;
    endfunction

endpackage : d_pkg

// File: rtl/d_sb_cnt.sv
// ----------------------------------------------------------------------------
// d_sb_cnt
//
// Purpose
//   One scoreboard counter. Holds the number of cycles until the pending
//   result for its register arrives at writeback. The counter counts down
//   to zero and sticks there; a nonzero value means the register is busy.
//
// Ports
//   clk      in  1   rising-edge clock
//   reset    in  1   asynchronous, active-low reset
//   load     in  1   accepted issue targets this register
//   load_val in  LW  clamped latency of that issue
//   clear    in  1   writeback to this register this cycle
//   flush    in  1   synchronous clear of all pending state
//   cnt      out LW  current count
//
// Priority of updates (highest first):
//   flush > load > clear > decrement
//   A load in the same cycle as a writeback to the same register belongs to
//   a newer instruction, so it must survive the writeback's clear.
// ----------------------------------------------------------------------------
module d_sb_cnt
    import d_pkg::*;
#(
    parameter int LW = D_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          clear,
    input  logic          flush,
    output logic [LW-1:0] cnt
);

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            // Saturating countdown: zero is held, never wrapped.
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : d_sb_cnt

// File: rtl/d_grf_sb.sv
// ----------------------------------------------------------------------------
// d_grf_sb
//
// Purpose
//   General register file with a per-register scoreboard. Reads are
//   combinational with a same-cycle writeback bypass. Every register has a
//   countdown of the cycles until its pending result is written back; a
//   read port whose register is still counting is not ready, and any
//   requested-but-not-ready port raises stall so decode holds.
//   Register 0 is hardwired to zero and is never tracked.
//
// Ports
//   clk        in  1        rising-edge clock
//   reset      in  1        asynchronous, active-low reset
//   ren        in  NR       per-port read-request mask
//   ra         in  NR*AW    packed read addresses, port i = [i*AW +: AW]
//   rd         out NR*DW    packed read data,      port i = [i*DW +: DW]
//   rdy        out NR       per-port operand valid
//   stall      out 1        decode must hold
//   we         in  1        writeback enable
//   wa         in  AW       writeback address
//   wd         in  DW       writeback data
//   iss_valid  in  1        decode issues a register-writing instruction
//   iss_rd     in  AW       destination of the issued instruction
//   iss_lat    in  LW       cycles until its result reaches writeback
//   flush      in  1        synchronous clear of all scoreboard state
//   busy       out NREG     per-register pending flag
//
// Issue handshake
//   iss_valid is the request and !stall is the ready. An issue is taken on
//   the rising edge only when iss_valid=1 and stall=0 in the same cycle; it
//   is additionally dropped when it targets register 0 or when flush=1.
//   Decode must keep the instruction (and iss_valid) presented while stall
//   is high; nothing is recorded for a cycle in which stall is high.
// ----------------------------------------------------------------------------
module d_grf_sb
    import d_pkg::*;
#(
    parameter  int DW     = D_DW,
    parameter  int NREG   = D_NREG,
    parameter  int NR     = D_NR,
    parameter  int MAXLAT = D_MAXLAT,
    localparam int AW     = $clog2(NREG),
    localparam int LW     = $clog2(MAXLAT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NR-1:0]      ren,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*DW-1:0]   rd,
    output logic [NR-1:0]      rdy,
    output logic               stall,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [DW-1:0]      wd,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    input  logic [LW-1:0]      iss_lat,
    input  logic               flush,
    output logic [NREG-1:0]    busy
);

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // Entry 0 is never written (write enable excludes wa==0) and the read
    // mux forces zero for address 0, so it reads as zero regardless.
    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    logic wr_en;
    assign wr_en = we && (wa != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    logic [NREG-1:0][LW-1:0] cnt;
    logic [LW-1:0]           lat_clamped;
    logic                    iss_acc;

    assign lat_clamped = LW'(clamp_lat(int'(iss_lat), MAXLAT));

    // stall depends only on ren/ra and the current counters, so using it
    // here does not form a combinational loop.
    assign iss_acc = iss_valid && !stall && (iss_rd != '0) && !flush;

    // Register 0 has no counter; its count is a constant zero.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        d_sb_cnt #(
            .LW       (LW)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .load     (iss_acc && (iss_rd == AW'(r))),
            .load_val (lat_clamped),
            .clear    (we && (wa == AW'(r))),
            .flush    (flush),
            .cnt      (cnt[r])
        );
    end

    assign busy[0] = 1'b0;
    for (genvar r = 1; r < NREG; r++) begin : g_busy
        assign busy[r] = (cnt[r] != '0);
    end

    // ------------------------------------------------------------------
    // Read ports: pure muxes, no state
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[i*AW +: AW];

        // A writeback landing this cycle is forwarded so the reader does
        // not see the stale stored value.
        assign rd[i*DW +: DW] = (addr == '0)               ? '0 :
                                (we && (wa == addr))       ? wd :
                                                             mem_q[addr];

        assign rdy[i] = (addr == '0) || (cnt[addr] == '0);
    end

    assign stall = |(ren & ~rdy);

endmodule : d_grf_sb

// File: tb/tb_d_grf_sb.sv
// ----------------------------------------------------------------------------
// tb_d_grf_sb
//
// Drives d_grf_sb with directed sequences followed by randomized traffic.
// A behavioural model of the register file and per-register pending
// latencies predicts rd/rdy/stall/busy for every cycle; the scoreboard
// process compares the DUT against it on each falling edge. Directed
// sequences add literal expectations computed by hand.
// ----------------------------------------------------------------------------
module tb_d_grf_sb;

    localparam int DW     = 32;
    localparam int NREG   = 32;
    localparam int NR     = 2;
    localparam int MAXLAT = 3;
    localparam int AW     = 5;
    localparam int LW     = 2;
    localparam int VW     = 1 + NR + NR*DW + NREG;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic [NR-1:0]     ren       = '0;
    logic [NR*AW-1:0]  ra        = '0;
    logic              we        = 1'b0;
    logic [AW-1:0]     wa        = '0;
    logic [DW-1:0]     wd        = '0;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_rd    = '0;
    logic [LW-1:0]     iss_lat   = '0;
    logic              flush     = 1'b0;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rdy;
    logic              stall;
    logic [NREG-1:0]   busy;

    always #5 clk = ~clk;

    d_grf_sb #(
        .DW        (DW),
        .NREG      (NREG),
        .NR        (NR),
        .MAXLAT    (MAXLAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ren       (ren),
        .ra        (ra),
        .rd        (rd),
        .rdy       (rdy),
        .stall     (stall),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_lat   (iss_lat),
        .flush     (flush),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Behavioural model and scoreboard
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] mem_m [NREG];
    int            pend_m [NREG];   // cycles until result arrives, 0 = none
    logic [VW-1:0] exp_q [$];

    function automatic int eff_lat(input int l);
        if (l < 1)      return 1;
        if (l > MAXLAT) return MAXLAT;
        return l;
    endfunction

    always @(negedge clk) begin : scoreboard
        logic [NR*DW-1:0] e_rd;
        logic [NR-1:0]    e_rdy;
        logic             e_stall;
        logic [NREG-1:0]  e_busy;
        logic [VW-1:0]    got_v;
        logic [VW-1:0]    exp_v;
        logic             acc;
        int               a;

        cyc++;
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem_m[r]  = '0;
                pend_m[r] = 0;
            end
        end

        // Outputs as a function of model state and present inputs.
        e_rd    = '0;
        e_rdy   = '0;
        e_stall = 1'b0;
        e_busy  = '0;
        for (int i = 0; i < NR; i++) begin
            a = int'(ra[i*AW +: AW]);
            if (a != 0) begin
                e_rd[i*DW +: DW] = (we && int'(wa) == a) ? wd : mem_m[a];
            end
            e_rdy[i] = (a == 0) || (pend_m[a] == 0);
            if (ren[i] && !e_rdy[i]) e_stall = 1'b1;
        end
        for (int r = 1; r < NREG; r++) begin
            e_busy[r] = (pend_m[r] != 0);
        end

        exp_q.push_back({e_stall, e_rdy, e_rd, e_busy});
        got_v = {stall, rdy, rd, busy};
        exp_v = exp_q.pop_front();
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle %0d outputs {stall,rdy,rd,busy}: got %h expected %h",
                     cyc, got_v, exp_v);
        end

        // State after the coming rising edge.
        if (reset) begin
            acc = iss_valid && !e_stall && (iss_rd != '0) && !flush;
            for (int r = 0; r < NREG; r++) begin
                if (pend_m[r] > 0) pend_m[r] = pend_m[r] - 1;
            end
            if (we && wa != '0) begin
                mem_m[wa]  = wd;
                pend_m[wa] = 0;
            end
            if (acc) pend_m[iss_rd] = eff_lat(int'(iss_lat));
            if (flush) begin
                for (int r = 0; r < NREG; r++) pend_m[r] = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic idle();
        ren       = '0;
        ra        = '0;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_lat   = '0;
        flush     = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ra(input int port, input int addr);
        ra[port*AW +: AW] = AW'(addr);
    endtask

    task automatic issue(input int r, input int l);
        iss_valid = 1'b1;
        iss_rd    = AW'(r);
        iss_lat   = LW'(l);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle();
        ren = 2'b11;
        set_ra(0, 7);
        set_ra(1, 0);
        mid();
        chk("reset_rd",    DW'(rd),    '0);
        chk("reset_rdy",   DW'(rdy),   DW'(2'b11));
        chk("reset_stall", DW'(stall), '0);
        chk("reset_busy",  DW'(busy),  '0);
        nxt();
        reset = 1'b1;
        mid();
        chk("post_reset_stall", DW'(stall), '0);
        chk("post_reset_busy",  DW'(busy),  '0);
        nxt();

        // Write then read, with same-cycle bypass.
        idle();
        we = 1'b1; wa = 5; wd = 32'h1234; ren = 2'b01; set_ra(0, 5);
        mid();
        chk("bypass_rd", rd[DW-1:0], 32'h1234);
        nxt();
        we = 1'b0;
        mid();
        chk("stored_rd", rd[DW-1:0], 32'h1234);
        nxt();

        // Scoreboard stall: three stalled cycles, then clear.
        idle();
        issue(8, 3);
        mid();
        nxt();
        idle();
        ren = 2'b01; set_ra(0, 8);
        for (int k = 0; k < 4; k++) begin
            mid();
            chk($sformatf("stall_cycle%0d", k), DW'(stall), (k < 3) ? 1 : 0);
            nxt();
        end

        // Writeback clear racing a new issue to the same register.
        idle();
        issue(8, 3);
        mid();
        nxt();
        idle();
        we = 1'b1; wa = 8; wd = 32'hAAAA_5555;
        issue(8, 2);
        mid();
        chk("race_busy_before", DW'(busy[8]), 1);
        nxt();
        idle();
        set_ra(0, 8);
        mid();
        chk("race_busy_lat2_a", DW'(busy[8]), 1);
        chk("race_rd8",         rd[DW-1:0],   32'hAAAA_5555);
        nxt();
        mid();
        chk("race_busy_lat2_b", DW'(busy[8]), 1);
        nxt();
        mid();
        chk("race_busy_done",   DW'(busy[8]), 0);
        nxt();

        // Register 0 ignores writes and issues.
        idle();
        we = 1'b1; wa = 0; wd = 32'hFFFF;
        issue(0, 3);
        ren = 2'b11;
        mid();
        chk("r0_rd_bypass", rd[DW-1:0], '0);
        chk("r0_stall",     DW'(stall), '0);
        chk("r0_busy",      DW'(busy),  '0);
        nxt();
        idle();
        ren = 2'b11;
        mid();
        chk("r0_rd_after",   rd[DW-1:0], '0);
        chk("r0_busy_after", DW'(busy),  '0);
        nxt();

        // Latency 0 behaves as latency 1.
        idle();
        issue(4, 0);
        mid();
        nxt();
        idle();
        mid();
        chk("lat0_busy",      DW'(busy[4]), 1);
        nxt();
        mid();
        chk("lat0_busy_done", DW'(busy[4]), 0);
        nxt();

        // Flush drops pending state.
        idle();
        issue(3, 3);
        mid();
        nxt();
        idle();
        flush = 1'b1;
        mid();
        chk("flush_busy_before", DW'(busy[3]), 1);
        nxt();
        idle();
        mid();
        chk("flush_busy_after", DW'(busy[3]), 0);
        nxt();

        // Reset mid-countdown clears data and pending state.
        idle();
        issue(3, 3);
        we = 1'b1; wa = 10; wd = 32'hBEEF;
        mid();
        nxt();
        idle();
        mid();
        chk("rst_busy_pending", DW'(busy[3]), 1);
        nxt();
        reset = 1'b0;
        ren = 2'b11; set_ra(0, 10); set_ra(1, 3);
        mid();
        chk("rst_rd10",  rd[DW-1:0],    '0);
        chk("rst_rd3",   rd[2*DW-1:DW], '0);
        chk("rst_stall", DW'(stall),    '0);
        chk("rst_busy",  DW'(busy),     '0);
        nxt();
        reset = 1'b1;
        mid();
        chk("rst_release_stall", DW'(stall), '0);
        chk("rst_release_rd10",  rd[DW-1:0], '0);
        nxt();

        // Issue presented while stalled must not be recorded.
        idle();
        issue(8, 3);
        mid();
        nxt();
        idle();
        ren = 2'b01; set_ra(0, 8);
        issue(9, 3);
        mid();
        chk("blocked_stall", DW'(stall), 1);
        nxt();
        idle();
        mid();
        chk("blocked_busy9", DW'(busy[9]), 0);
        nxt();

        // Randomized traffic over a small register window.
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset     = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            ren       = NR'($urandom_range(0, 3));
            set_ra(0, $urandom_range(0, 7));
            set_ra(1, $urandom_range(0, 7));
            we        = ($urandom_range(0, 2) == 0);
            wa        = AW'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = AW'($urandom_range(0, 7));
            iss_lat   = LW'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 19) == 0);
            nxt();
        end

        idle();
        reset = 1'b1;
        nxt();
        mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_d_grf_sb
